titan_wb_arbiter: RTL and testbench
===================================

Name: titan_wb_arbiter

Overview:
Two-master, one-slave Wishbone arbiter that shares a single memory bus between the Titan LSU instruction port and data port. It sits between the LSU memory ports and the unified memory/interconnect. It grants the bus on a round-robin basis and holds each grant for a whole master cycle (cyc high). A bus-timeout watchdog terminates any transfer the slave never acknowledges.

Parameters:
TIMEOUT_CYCLES, 16, wait cycles without ack/err before the arbiter forces err; 0 disables the watchdog; range 0..65535.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
iaddr_i  in  32  instruction master address
icyc_i  in  1  instruction master cycle
istb_i  in  1  instruction master strobe
idat_o  out  32  read data to instruction master
iack_o  out  1  ack to instruction master
ierr_o  out  1  err to instruction master
daddr_i  in  32  data master address
ddat_i  in  32  data master write data
dsel_i  in  4  data master byte select
dwe_i  in  1  data master write enable
dcyc_i  in  1  data master cycle
dstb_i  in  1  data master strobe
ddat_o  out  32  read data to data master
dack_o  out  1  ack to data master
derr_o  out  1  err to data master
waddr_o  out  32  slave address
wdat_o  out  32  slave write data
wsel_o  out  4  slave byte select
wwe_o  out  1  slave write enable
wcyc_o  out  1  slave cycle
wstb_o  out  1  slave strobe
wdat_i  in  32  slave read data
wack_i  in  1  slave ack
werr_i  in  1  slave err

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high on rst_i.
- States: IDLE, GNT_I, GNT_D. Registered state, registered last_grant, 16-bit wait counter, registered tmo pulse.
- Reset: state=IDLE, last_grant=I (so D wins the first tie), counter=0, tmo=0.
- All outputs at reset/IDLE: waddr_o=0, wdat_o=0, wsel_o=0, wwe_o=0, wcyc_o=0, wstb_o=0, iack_o=ierr_o=dack_o=derr_o=0. idat_o and ddat_o always equal wdat_i.
- IDLE transitions:
  - icyc_i only -> GNT_I.
  - dcyc_i only -> GNT_D.
  - Both -> the master that is not last_grant.
  - Arbitration latency is 1 cycle: the slave sees the request the cycle after cyc rises.
- GNT_x: slave outputs are a combinational mux of master x.
  - Instruction master: wwe_o=0, wsel_o=4'hf, wdat_o=0.
  - wcyc_o=xcyc & ~tmo; wstb_o=xstb & ~tmo.
  - xack_o=wack_i; xerr_o=werr_i | tmo.
  - The non-granted master's ack/err are 0.
  - last_grant<=x on entry.
- Release: when the granted master's cyc is 0 at a clock edge:
  - other master's cyc=1 -> switch directly to its grant (no IDLE cycle);
  - else -> IDLE.
  - A grant is never pre-empted while its cyc is held; multi-beat cycles keep the bus.
- Watchdog:
  - Counter increments each cycle in GNT_x with xstb=1, wack_i=0, werr_i=0 and tmo=0.
  - Counter clears on ack, err, tmo, or any state change.
  - When counter reaches TIMEOUT_CYCLES-1 with no ack/err, tmo<=1 for exactly one cycle.
  - During tmo the master sees err and the slave sees cyc/stb=0. A slave ack arriving during tmo is ignored.
  - TIMEOUT_CYCLES=0: tmo never asserts.
- Simultaneous events:
  - Ack and cyc drop on the same edge is normal completion.
  - Err from slave and tmo together produce a single err.
- Reset mid-transaction: the next cycle is IDLE with wcyc_o=0. The aborted master receives no ack.

Test Plan:
- Single fetch: icyc_i=istb_i=1, iaddr_i=0x100; slave acks 2 cycles after wstb_o with wdat_i=0x00000013 -> waddr_o=0x100 one cycle after request, wsel_o=4'hf, wwe_o=0, iack_o one-cycle pulse with idat_o=0x13, dack_o=0.
- Write pass-through: dwe_i=1, dsel_i=4'h3, ddat_i=0x0000BEEF, daddr_i=0x2004 -> slave sees identical values; dack_o follows wack_i; iack_o stays 0.
- Tie after reset: icyc_i and dcyc_i rise together -> GNT_D first. On the edge dcyc_i drops, the arbiter moves directly to GNT_I with no IDLE cycle.
- Sustained contention: both masters issue back-to-back single-beat cycles, dropping cyc after each ack -> grants alternate D,I,D,I; neither master starves.
- Timeout: TIMEOUT_CYCLES=16, data read, slave silent -> derr_o pulses exactly once on the 16th wait cycle, with wcyc_o=wstb_o=0 that cycle and dack_o never asserted. Repeat with TIMEOUT_CYCLES=0 -> no err after 100 cycles.
- Reset mid-op: assert rst_i for 1 cycle while in GNT_D waiting on ack -> next cycle wcyc_o=0, all acks/errs 0. A subsequent tie grants D first.

Source files
------------

// File: rtl/titan_wb_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter with round-robin
// grant held for a whole master cycle and a bus-timeout watchdog.
module titan_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] iaddr_i,
    input  logic        icyc_i,
    input  logic        istb_i,
    output logic [31:0] idat_o,
    output logic        iack_o,
    output logic        ierr_o,
    input  logic [31:0] daddr_i,
    input  logic [31:0] ddat_i,
    input  logic [3:0]  dsel_i,
    input  logic        dwe_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    output logic [31:0] ddat_o,
    output logic        dack_o,
    output logic        derr_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdat_o,
    output logic [3:0]  wsel_o,
    output logic        wwe_o,
    output logic        wcyc_o,
    output logic        wstb_o,
    input  logic [31:0] wdat_i,
    input  logic        wack_i,
    input  logic        werr_i
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t      state_q, state_d;
    logic        last_d_q;
    logic [15:0] cnt_q;
    logic        tmo_q;
    logic        gnt_stb;
    logic        waiting;
    logic        changing;
    logic        tmo_set;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (icyc_i && dcyc_i) state_d = last_d_q ? GNT_I : GNT_D;
                else if (icyc_i)      state_d = GNT_I;
                else if (dcyc_i)      state_d = GNT_D;
            end
            GNT_I: if (!icyc_i) state_d = dcyc_i ? GNT_D : IDLE;
            GNT_D: if (!dcyc_i) state_d = icyc_i ? GNT_I : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idat_o  = wdat_i;
        ddat_o  = wdat_i;
        iack_o  = 1'b0;
        ierr_o  = 1'b0;
        dack_o  = 1'b0;
        derr_o  = 1'b0;
        waddr_o = '0;
        wdat_o  = '0;
        wsel_o  = '0;
        wwe_o   = 1'b0;
        wcyc_o  = 1'b0;
        wstb_o  = 1'b0;
        gnt_stb = 1'b0;
        case (state_q)
            GNT_I: begin
                waddr_o = iaddr_i;
                wsel_o  = 4'hf;
                wcyc_o  = icyc_i & ~tmo_q;
                wstb_o  = istb_i & ~tmo_q;
                iack_o  = wack_i & ~tmo_q;
                ierr_o  = werr_i | tmo_q;
                gnt_stb = istb_i;
            end
            GNT_D: begin
                waddr_o = daddr_i;
                wdat_o  = ddat_i;
                wsel_o  = dsel_i;
                wwe_o   = dwe_i;
                wcyc_o  = dcyc_i & ~tmo_q;
                wstb_o  = dstb_i & ~tmo_q;
                dack_o  = wack_i & ~tmo_q;
                derr_o  = werr_i | tmo_q;
                gnt_stb = dstb_i;
            end
            default: ;
        endcase
    end

    assign waiting  = gnt_stb && !wack_i && !werr_i && !tmo_q;
    assign changing = (state_d != state_q);
    // tmo is registered, so it is launched one count early: the err lands in
    // the same cycle the counter holds TIMEOUT_CYCLES-1.
    assign tmo_set  = (TIMEOUT_CYCLES != 0) && waiting && !changing &&
                      (({1'b0, cnt_q} + 17'd2) >= 17'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (changing && state_d == GNT_I) last_d_q <= 1'b0;
            if (changing && state_d == GNT_D) last_d_q <= 1'b1;
            if (changing || state_q == IDLE || wack_i || werr_i || tmo_q)
                cnt_q <= '0;
            else if (waiting)
                cnt_q <= cnt_q + 16'd1;
            tmo_q <= tmo_set;
        end
    end

endmodule

// File: tb/tb_titan_wb_arbiter.sv
// Directed self-checking bench for titan_wb_arbiter (watchdog on and off).
module tb_titan_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr, daddr, ddat, wdat_i;
    logic        icyc, istb, dcyc, dstb, dwe, wack, werr;
    logic [3:0]  dsel;

    logic [31:0] idat_o, ddat_o, waddr_o, wdat_o;
    logic        iack_o, ierr_o, dack_o, derr_o, wwe_o, wcyc_o, wstb_o;
    logic [3:0]  wsel_o;

    logic [31:0] idat0, ddat0, waddr0, wdat0;
    logic        iack0, ierr0, dack0, derr0, wwe0, wcyc0, wstb0;
    logic [3:0]  wsel0;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    titan_wb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .iaddr_i(iaddr), .icyc_i(icyc), .istb_i(istb),
        .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
        .daddr_i(daddr), .ddat_i(ddat), .dsel_i(dsel), .dwe_i(dwe),
        .dcyc_i(dcyc), .dstb_i(dstb),
        .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
        .waddr_o(waddr_o), .wdat_o(wdat_o), .wsel_o(wsel_o), .wwe_o(wwe_o),
        .wcyc_o(wcyc_o), .wstb_o(wstb_o),
        .wdat_i(wdat_i), .wack_i(wack), .werr_i(werr)
    );

    titan_wb_arbiter #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .iaddr_i(iaddr), .icyc_i(icyc), .istb_i(istb),
        .idat_o(idat0), .iack_o(iack0), .ierr_o(ierr0),
        .daddr_i(daddr), .ddat_i(ddat), .dsel_i(dsel), .dwe_i(dwe),
        .dcyc_i(dcyc), .dstb_i(dstb),
        .ddat_o(ddat0), .dack_o(dack0), .derr_o(derr0),
        .waddr_o(waddr0), .wdat_o(wdat0), .wsel_o(wsel0), .wwe_o(wwe0),
        .wcyc_o(wcyc0), .wstb_o(wstb0),
        .wdat_i(wdat_i), .wack_i(wack), .werr_i(werr)
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        icyc = 0; istb = 0; dcyc = 0; dstb = 0; wack = 0; werr = 0;
    endtask

    task automatic test_reset();
        logic [77:0] got;
        rst = 1; idle_inputs();
        iaddr = 32'h1234; daddr = 32'h5678; ddat = 32'hFFFF_FFFF; dsel = 4'hf; dwe = 1;
        wdat_i = 32'h0000_A5A5;
        tick(); tick();
        rst = 0;
        #2;
        got = {waddr_o, wdat_o, wsel_o, wwe_o, wcyc_o, wstb_o, iack_o, ierr_o, dack_o, derr_o};
        total++;
        if (got !== '0) $display("FAIL reset_outputs got=%h exp=0", got);
        else passed++;
        total++;
        if ({idat_o, ddat_o} !== {32'h0000_A5A5, 32'h0000_A5A5})
            $display("FAIL read_data_passthru got=%h/%h exp=0000a5a5", idat_o, ddat_o);
        else passed++;
        dwe = 0; dsel = 4'h0; ddat = 32'h0;
    endtask

    task automatic test_single_fetch();
        tick();
        icyc = 1; istb = 1; iaddr = 32'h100;
        #2;
        total++;
        if (wcyc_o !== 1'b0) $display("FAIL fetch_latency wcyc got=%b exp=0", wcyc_o);
        else passed++;
        tick(); #2;
        total++;
        if ({waddr_o, wsel_o, wwe_o, wcyc_o, wstb_o} !== {32'h100, 4'hf, 1'b0, 1'b1, 1'b1})
            $display("FAIL fetch_bus got=%h %h %b%b%b exp=100 f 011", waddr_o, wsel_o, wwe_o, wcyc_o, wstb_o);
        else passed++;
        tick(); #2;
        total++;
        if (iack_o !== 1'b0) $display("FAIL fetch_early_ack got=%b exp=0", iack_o);
        else passed++;
        tick();
        wack = 1; wdat_i = 32'h13;
        #2;
        total++;
        if ({iack_o, idat_o, dack_o} !== {1'b1, 32'h13, 1'b0})
            $display("FAIL fetch_ack got=%b %h %b exp=1 00000013 0", iack_o, idat_o, dack_o);
        else passed++;
        tick();
        icyc = 0; istb = 0; wack = 0;
        #2;
        total++;
        if ({iack_o, wcyc_o} !== 2'b00) $display("FAIL fetch_ack_pulse got=%b%b exp=00", iack_o, wcyc_o);
        else passed++;
        tick();
    endtask

    task automatic test_write();
        tick();
        dcyc = 1; dstb = 1; dwe = 1; dsel = 4'h3; ddat = 32'h0000_BEEF; daddr = 32'h2004;
        tick();
        wack = 1;
        #2;
        total++;
        if ({waddr_o, wdat_o, wsel_o, wwe_o, wcyc_o, wstb_o} !== {32'h2004, 32'h0000_BEEF, 4'h3, 3'b111})
            $display("FAIL write_bus got=%h %h %h %b%b%b exp=2004 0000beef 3 111",
                     waddr_o, wdat_o, wsel_o, wwe_o, wcyc_o, wstb_o);
        else passed++;
        total++;
        if ({dack_o, iack_o} !== 2'b10) $display("FAIL write_ack got=%b%b exp=10", dack_o, iack_o);
        else passed++;
        tick();
        idle_inputs(); dwe = 0;
        tick();
    endtask

    task automatic test_slave_err();
        tick();
        dcyc = 1; dstb = 1; daddr = 32'h700;
        tick();
        werr = 1;
        #2;
        total++;
        if ({derr_o, dack_o, ierr_o} !== 3'b100)
            $display("FAIL slave_err got=%b%b%b exp=100", derr_o, dack_o, ierr_o);
        else passed++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        tick();
        iaddr = 32'h40; daddr = 32'h80;
        icyc = 1; istb = 1; dcyc = 1; dstb = 1;
        // last grant before this test was D, so I goes first here.
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h40 : 32'h80;
            tick();
            icyc = 1; istb = 1; dcyc = 1; dstb = 1; wack = 1;
            #2;
            total++;
            if ({waddr_o, wcyc_o} !== {exp_addr, 1'b1})
                $display("FAIL contention_grant%0d got=%h/%b exp=%h/1", k, waddr_o, wcyc_o, exp_addr);
            else passed++;
            tick();
            wack = 0;
            if (k % 2 == 0) begin icyc = 0; istb = 0; end
            else begin dcyc = 0; dstb = 0; end
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_tie_after_reset();
        tick();
        rst = 1;
        tick();
        rst = 0;
        iaddr = 32'h40; daddr = 32'h80; dwe = 0;
        icyc = 1; istb = 1; dcyc = 1; dstb = 1;
        tick();
        wack = 1;
        #2;
        total++;
        if ({waddr_o, dack_o, iack_o} !== {32'h80, 2'b10})
            $display("FAIL tie_first_d got=%h %b%b exp=80 10", waddr_o, dack_o, iack_o);
        else passed++;
        tick();
        dcyc = 0; dstb = 0; wack = 0;
        tick();
        wack = 1;
        #2;
        total++;
        if ({waddr_o, wcyc_o, iack_o} !== {32'h40, 2'b11})
            $display("FAIL tie_handover_i got=%h %b%b exp=40 11", waddr_o, wcyc_o, iack_o);
        else passed++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int unsigned first_err, nerr, nack, nerr0;
        logic [1:0]  bus_at_err;
        first_err = 0; nerr = 0; nack = 0; nerr0 = 0; bus_at_err = 2'b11;
        tick();
        dcyc = 1; dstb = 1; dwe = 0; daddr = 32'h300;
        for (int k = 1; k <= 100; k++) begin
            tick(); #2;
            if (k <= 20) begin
                if (derr_o === 1'b1) begin
                    nerr++;
                    if (first_err == 0) begin
                        first_err = k;
                        bus_at_err = {wcyc_o, wstb_o};
                    end
                end
                if (dack_o !== 1'b0) nack++;
            end
            if (derr0 !== 1'b0) nerr0++;
        end
        total++;
        if (first_err != 16) $display("FAIL tmo_cycle got=%0d exp=16", first_err);
        else passed++;
        total++;
        if (nerr != 1) $display("FAIL tmo_single_pulse got=%0d exp=1", nerr);
        else passed++;
        total++;
        if (bus_at_err !== 2'b00) $display("FAIL tmo_bus_gated got=%b exp=00", bus_at_err);
        else passed++;
        total++;
        if (nack != 0) $display("FAIL tmo_no_ack got=%0d exp=0", nack);
        else passed++;
        total++;
        if ({nerr0, wstb0} !== {32'd0, 1'b1})
            $display("FAIL tmo_disabled errs=%0d stb=%b exp=0 1", nerr0, wstb0);
        else passed++;
        tick();
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid_op();
        tick();
        dcyc = 1; dstb = 1; daddr = 32'h500;
        tick(); tick(); tick();
        rst = 1; icyc = 1; istb = 1; iaddr = 32'h600;
        tick();
        rst = 0; wack = 1;
        #2;
        total++;
        if ({wcyc_o, wstb_o, iack_o, ierr_o, dack_o, derr_o} !== 6'b0)
            $display("FAIL reset_mid_abort got=%b%b%b%b%b%b exp=000000",
                     wcyc_o, wstb_o, iack_o, ierr_o, dack_o, derr_o);
        else passed++;
        tick();
        wack = 0;
        #2;
        total++;
        if ({waddr_o, wcyc_o} !== {32'h500, 1'b1})
            $display("FAIL reset_mid_tie got=%h/%b exp=500/1", waddr_o, wcyc_o);
        else passed++;
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_write();
        test_slave_err();
        test_contention();
        test_tie_after_reset();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
